// File: rtl/mux_pkg.sv
// Shared definitions for the mux bank and its skew feeder.
//   LANES_DEFAULT      : lane count, one per upstream mux output
//   DATA_WIDTH_DEFAULT : data bits per lane
//   state_t            : feeder burst-control states
package mux_pkg;

    localparam int unsigned LANES_DEFAULT      = 64;
    localparam int unsigned DATA_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

endpackage

// File: rtl/skew_lane.sv
// One enabled delay line of DEPTH stages, each stage carrying data plus a
// valid bit. A bubble (zero data, valid 0) enters whenever load is low.
//   clk, rst_n      : clock, synchronous active-low reset
//   adv             : advance enable; all stages hold when low
//   load, din       : stage-1 load request and data
//   dout_valid,dout : last stage; dout is zero while dout_valid is low
module skew_lane #(
    parameter int unsigned DEPTH      = 1,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  adv,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  dout_valid,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < DEPTH; s++) begin
                data_q[s] <= '0;
            end
            valid_q <= '0;
        end else if (adv) begin
            data_q[0]  <= load ? din : '0;
            valid_q[0] <= load;
            for (int unsigned s = 1; s < DEPTH; s++) begin
                data_q[s]  <= data_q[s-1];
                valid_q[s] <= valid_q[s-1];
            end
        end
    end

    assign dout_valid = valid_q[DEPTH-1];
    assign dout       = valid_q[DEPTH-1] ? data_q[DEPTH-1] : '0;

endmodule

// File: rtl/mux_skew_feeder.sv
// Diagonal skew feeder between the mux bank and a systolic array. Lane i
// delays its element by i+1 advances so that one input vector reaches the
// array as a diagonal wavefront. After the final vector of a burst the
// block stops accepting until that vector has fully left lane LANES-1.
//   clk, rst_n               : clock, synchronous active-low reset
//   in_valid/in_ready        : input handshake; in_last marks burst end
//   in_data[0:LANES-1]       : one mux output per lane
//   out_data[0:LANES-1]      : skewed lane outputs (zero when lane invalid)
//   out_lane_valid, out_valid: per-lane valid and their OR
//   out_ready                : downstream advance; everything holds when low
//   drain_done               : burst's last element is on lane LANES-1
module mux_skew_feeder
    import mux_pkg::*;
#(
    parameter int unsigned LANES      = LANES_DEFAULT,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [DATA_WIDTH-1:0] in_data [0:LANES-1],
    output logic [DATA_WIDTH-1:0] out_data [0:LANES-1],
    output logic [LANES-1:0]      out_lane_valid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  drain_done
);

    localparam int unsigned    CW       = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CW-1:0]  CNT_LOAD = CW'(LANES - 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          adv;
    logic          accept;

    logic [LANES-1:0]      lane_valid;
    logic [DATA_WIDTH-1:0] lane_data [0:LANES-1];

    assign adv = out_ready;

    // Reset is synchronous, so outputs are gated by rst_n to present the
    // idle view for the whole time reset is held, not just after the edge.
    assign in_ready = out_ready && (!rst_n || (state != DRAIN));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (adv) begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE, STREAM: begin
                if (accept) begin
                    if (in_last) begin
                        state_n = DRAIN;
                        cnt_n   = CNT_LOAD;
                    end else begin
                        state_n = STREAM;
                    end
                end
            end
            DRAIN: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign drain_done = rst_n && (state == DRAIN) && (cnt == '0);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        skew_lane #(
            .DEPTH      (i + 1),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .adv        (adv),
            .load       (accept),
            .din        (in_data[i]),
            .dout_valid (lane_valid[i]),
            .dout       (lane_data[i])
        );
        assign out_lane_valid[i] = rst_n && lane_valid[i];
        assign out_data[i]       = rst_n ? lane_data[i] : '0;
    end

    assign out_valid = |out_lane_valid;

endmodule
